mem_byte_sequencer: RTL and testbench
=====================================

MEM_BYTE_SEQUENCER -- requirements
Module: mem_byte_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, default 5, byte-address width of the attached byte memory (32 bytes at default).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  word access request from the processor datapath.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port: req_write  input  1  1 = word store, 0 = word load.
REQ-007 SHALL have port: req_addr  input  32  byte address (ALU result); only [ADDR_W-1:0] used.
REQ-008 SHALL have port: req_wdata  input  32  store data (register-file read data 2).
REQ-009 SHALL have port: rsp_valid  output  1  completion; held until accepted.
REQ-010 SHALL have port: rsp_ready  input  1  completion consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-011 SHALL have port: rsp_rdata  output  32  assembled load data; 0 for stores and errors.
REQ-012 SHALL have port: rsp_err  output  1  misaligned-access flag, valid with rsp_valid.
REQ-013 SHALL have port: mem_addr  output  ADDR_W  byte address to memory.
REQ-014 SHALL have port: mem_we  output  1  byte write strobe, sampled by memory at rising edge.
REQ-015 SHALL have port: mem_wdata  output  8  byte write data.
REQ-016 SHALL have port: mem_rdata  input  8  asynchronous (combinational) byte read data for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, XFER, RESP.
REQ-018 SHALL assert req_ready only in IDLE; on acceptance SHALL latch write flag, address[ADDR_W-1:0], wdata, clear beat counter, enter XFER.
REQ-019 SHALL in XFER perform 4 beats, counter k = 0..3, one per cycle; mem_addr = (base + k) mod 2^ADDR_W (wraps, no carry beyond ADDR_W).
REQ-020 SHALL order bytes big-endian: beat 0 <-> bits [31:24], beat 1 <-> [23:16], beat 2 <-> [15:8], beat 3 <-> [7:0].
REQ-021 SHALL for stores drive mem_we=1 and mem_wdata = selected byte on all 4 beats; for loads mem_we=0 and capture mem_rdata into the selected byte lane at each beat's rising edge.
REQ-022 SHALL go XFER->RESP after beat 3; request accepted at edge N gives beats in cycles N+1..N+4, rsp_valid high from cycle N+5.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; on handshake return to IDLE; new request acceptable the cycle after.
REQ-024 SHALL drive mem_we=0 at all times outside XFER; mem_addr = 0, mem_wdata = 0 outside XFER.
REQ-025 SHALL ignore req_* changes while not in IDLE.
REQ-026 SHALL never assert rsp_valid in IDLE or XFER.

Reset
REQ-027 SHALL on rst_n low immediately (asynchronously) enter IDLE, clear counter and latched data; outputs: req_ready=1 once released... during reset req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 SHALL abort any in-progress access on reset; no further mem_we pulses for that access; bytes already written are not undone.
REQ-029 SHALL assert req_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL compile misalignment checking when macro MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN is defined: request with req_addr[1:0] != 0 goes IDLE->RESP directly (no XFER, no mem_we), rsp_valid one cycle after acceptance with rsp_err=1, rsp_rdata=0.
REQ-031 SHALL without the macro treat every address as valid (rsp_err tied 0), using byte wrap per REQ-019.

Verification
REQ-032 SHALL verify store: addr 0x08, wdata 0xA1B2C3D4 -> mem bytes [8]=A1,[9]=B2,[10]=C3,[11]=D4, rsp_valid 5 cycles after acceptance, rsp_err=0.
REQ-033 SHALL verify load: memory [12..15]=11,22,33,44, addr 0x0C -> rsp_rdata=0x11223344.
REQ-034 SHALL verify wrap: store addr 0x1E (macro undefined), wdata 0xDEADBEEF -> [30]=DE,[31]=AD,[0]=BE,[1]=EF.
REQ-035 SHALL verify backpressure: rsp_ready low 3 cycles -> rsp_valid/rsp_rdata held, req_ready=0 throughout.
REQ-036 SHALL verify reset mid-store after beat 1: bytes 0,1 written, bytes 2,3 unchanged, all outputs at reset values, req_ready=1 after release.
REQ-037 SHALL verify with macro defined: load addr 0x05 -> rsp_err=1, rsp_rdata=0, no mem_we, rsp_valid 1 cycle after acceptance.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: turns one 32-bit word load/store into four big-endian
// byte beats on a byte-wide memory with combinational read data.
// Optional build macro MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN rejects word
// accesses whose low two address bits are non-zero with rsp_err, without
// touching memory.
module mem_byte_sequencer #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // Big-endian lane k of a word: k=0 is bits [31:24].
    function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] d,
                                                  input logic [CNT_W-1:0]  k);
        byte_of = d[31:24];
        case (k)
            2'd0: byte_of = d[31:24];
            2'd1: byte_of = d[23:16];
            2'd2: byte_of = d[15:8];
            2'd3: byte_of = d[7:0];
            default: byte_of = d[31:24];
        endcase
    endfunction

    // Replace big-endian lane k of a word with byte b.
    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] d,
                                                   input logic [CNT_W-1:0]  k,
                                                   input logic [BYTE_W-1:0] b);
        put_byte = d;
        case (k)
            2'd0: put_byte[31:24] = b;
            2'd1: put_byte[23:16] = b;
            2'd2: put_byte[15:8]  = b;
            2'd3: put_byte[7:0]   = b;
            default: put_byte = d;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                r_write;
    logic                w_write_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                r_req_ready;
    logic                w_req_ready_nxt;
    logic                r_rsp_valid;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic                r_mem_we;
    logic                w_mem_we_nxt;
    logic [BYTE_W-1:0]   r_mem_wdata;
    logic [BYTE_W-1:0]   w_mem_wdata_nxt;
    logic                w_accept;
    logic                w_unused_addr;
`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
    logic                r_rsp_err;
    logic                w_rsp_err_nxt;
`endif

    // Upper request address bits lie outside the attached memory.
    assign w_unused_addr = ^req_addr[31:ADDR_W];

    assign w_accept  = (r_state == IDLE) && req_valid && r_req_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next values of every registered output and latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_write_nxt     = r_write;
        w_base_nxt      = r_base;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_req_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_mem_addr_nxt  = '0;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = '0;
`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
        w_rsp_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    w_write_nxt     = req_write;
                    w_base_nxt      = req_addr[ADDR_W-1:0];
                    w_wdata_nxt     = req_wdata;
                    w_cnt_nxt       = '0;
                    w_rdata_nxt     = '0;
`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
                    if (req_addr[1:0] != 2'b00) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = XFER;
                        w_mem_addr_nxt  = req_addr[ADDR_W-1:0];
                        w_mem_we_nxt    = req_write;
                        w_mem_wdata_nxt = req_write ? req_wdata[31:24] : '0;
                    end
`else
                    w_state_nxt     = XFER;
                    w_mem_addr_nxt  = req_addr[ADDR_W-1:0];
                    w_mem_we_nxt    = req_write;
                    w_mem_wdata_nxt = req_write ? req_wdata[31:24] : '0;
`endif
                end
            end
            XFER: begin
                if (!r_write) begin
                    w_rdata_nxt = put_byte(r_rdata, r_cnt, mem_rdata);
                end
                if (r_cnt == LAST_BEAT) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_write ? '0 : w_rdata_nxt;
                end else begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_mem_addr_nxt  = r_base + ADDR_W'(w_cnt_inc);
                    w_mem_we_nxt    = r_write;
                    w_mem_wdata_nxt = r_write ? byte_of(r_wdata, w_cnt_inc) : '0;
                end
            end
            RESP: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
                w_rsp_err_nxt   = r_rsp_err;
`endif
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_req_ready_nxt = 1'b1;
`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
                    w_rsp_err_nxt   = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Access latches and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_write     <= w_write_nxt;
            r_base      <= w_base_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
    // Misalignment flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else begin
            r_rsp_err <= w_rsp_err_nxt;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a 32-byte behavioural memory.
module tb_mem_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:31];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [7:0]  pre_data;
    int          we_cnt = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    mem_byte_sequencer #(.ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: DUT strobe has priority over bench preload.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end
    assign mem_rdata = mem[mem_addr];

    // Count every write strobe seen by the memory.
    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pre_write(input logic [4:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
        check({tag, "_mem"}, {22'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    endtask

    // Issue one request and wait (bounded) for rsp_valid; lat counts cycles
    // after acceptance, beats are cycles 1..4. Response is left pending.
    task automatic start_req(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat, input bit disturb);
        int          lat;
        int          k;
        logic [31:0] sh;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = disturb;
        req_write = ~wr;
        req_addr  = 32'h0000_0013;
        req_wdata = 32'h5A5A_5A5A;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            k = lat - 1;
            if (exp_lat == 5 && k < 4) begin
                check({tag, "_beat_addr"}, {27'd0, mem_addr}, {27'd0, 5'(addr[4:0] + 5'(k))});
                check({tag, "_beat_we"}, {31'd0, mem_we}, {31'd0, wr});
                if (wr) begin
                    sh = wdata >> (8 * (3 - k));
                    check({tag, "_beat_wdata"}, {24'd0, mem_wdata}, {24'd0, sh[7:0]});
                end
            end
            check({tag, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
            step();
            lat++;
        end
        req_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int base;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        #3 rst_n = 1'b0;

        // Preload memory while the DUT is held in reset.
        for (int i = 0; i < 32; i++) pre_write(5'(i), 8'(8'h40 + i));
        pre_write(5'd12, 8'h11);
        pre_write(5'd13, 8'h22);
        pre_write(5'd14, 8'h33);
        pre_write(5'd15, 8'h44);
        check_reset_outputs("rst");

        rst_n = 1'b1;
        step();
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Store to aligned address.
        base = we_cnt;
        start_req("st08", 1'b1, 32'h0000_0008, 32'hA1B2_C3D4, 5, 1'b0);
        check("st08_err", {31'd0, rsp_err}, 32'd0);
        check("st08_rdata", rsp_rdata, 32'd0);
        finish_rsp("st08");
        check("st08_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hA1B2_C3D4);
        check("st08_pulses", 32'(we_cnt - base), 32'd4);
        check("st08_neighbours", {16'd0, mem[7], mem[12]}, 32'h0000_4711);

        // Load with req_* disturbed while busy; nothing may be written.
        base = we_cnt;
        start_req("ld0c", 1'b0, 32'h0000_000C, 32'hFFFF_FFFF, 5, 1'b1);
        check("ld0c_rdata", rsp_rdata, 32'h1122_3344);
        check("ld0c_err", {31'd0, rsp_err}, 32'd0);
        finish_rsp("ld0c");
        check("ld0c_pulses", 32'(we_cnt - base), 32'd0);

`ifndef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
        // Store that wraps past the top of the byte memory.
        start_req("st1e", 1'b1, 32'h0000_001E, 32'hDEAD_BEEF, 5, 1'b0);
        check("st1e_err", {31'd0, rsp_err}, 32'd0);
        finish_rsp("st1e");
        check("st1e_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'hDEAD_BEEF);
        check("st1e_mem29_2", {16'd0, mem[29], mem[2]}, 32'h0000_5D42);
`endif

        // Backpressure: response must hold for three cycles.
        start_req("bp", 1'b0, 32'h0000_000C, 32'h0, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, 32'h1122_3344);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        check("bp_valid_end", {31'd0, rsp_valid}, 32'd1);
        finish_rsp("bp");

        // Reset after beat 1 of a store at address 0.
        pre_write(5'd0, 8'h40);
        pre_write(5'd1, 8'h41);
        base = we_cnt;
        check("rs_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'h1234_5678;
        step();
        req_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rs");
        step();
        step();
        check_reset_outputs("rs_hold");
        check("rs_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h1234_4243);
        check("rs_pulses", 32'(we_cnt - base), 32'd2);
        rst_n = 1'b1;
        step();
        check("rs_release_ready", {31'd0, req_ready}, 32'd1);
        check("rs_release_valid", {31'd0, rsp_valid}, 32'd0);

        // Normal operation resumes after the aborted access.
        start_req("ld08", 1'b0, 32'h0000_0008, 32'h0, 5, 1'b0);
        check("ld08_rdata", rsp_rdata, 32'hA1B2_C3D4);
        finish_rsp("ld08");

`ifdef MEM_BYTE_SEQUENCER_ALIGN_CHECK_EN
        // Misaligned load is answered with an error without memory traffic.
        base = we_cnt;
        start_req("mis05", 1'b0, 32'h0000_0005, 32'h0, 1, 1'b0);
        check("mis05_err", {31'd0, rsp_err}, 32'd1);
        check("mis05_rdata", rsp_rdata, 32'd0);
        finish_rsp("mis05");
        check("mis05_err_clr", {31'd0, rsp_err}, 32'd0);
        check("mis05_pulses", 32'(we_cnt - base), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
